cam_cmd_sequencer: RTL and testbench

- Command-level controller that sits between the USB-serial command parser and the CAM array.
- Accepts one opcode and operand per valid/ready handshake and drives the CAM control lines (comparand, mask, perform_search, set, select_first, write_lines) with correct pulse widths.
- Holds each strobe for a programmable settle window, then samples tag_wires or read_lines.
- Returns one response per command over a second valid/ready channel. The parser no longer hand-times CAM strobes.

---
 rtl/cam_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cam_cmd_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_sequencer.sv
// Command sequencer between the serial parser and the CAM array.
// Define CAM_SEQ_TAG_COUNT_EN to return the tag popcount for SEARCH.
module cam_cmd_sequencer #(
  parameter int NUM_BITS      = 32,
  parameter int NUM_CELLS     = 16,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [NUM_BITS-1:0]   cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NUM_BITS-1:0]   rsp_data,
  output logic                  rsp_err,
  output logic [NUM_BITS-1:0]   comparand,
  output logic [NUM_BITS-1:0]   mask,
  output logic                  perform_search,
  output logic                  set,
  output logic                  select_first,
  output logic [2*NUM_BITS-1:0] write_lines,
  input  logic [NUM_CELLS-1:0]  tag_wires,
  input  logic [NUM_BITS-1:0]   read_lines
);

  localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0] CNT_INIT = 8'(SC - 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LCMP = 3'd1;
  localparam logic [2:0] OP_LMSK = 3'd2;
  localparam logic [2:0] OP_SRCH = 3'd3;
  localparam logic [2:0] OP_SELF = 3'd4;
  localparam logic [2:0] OP_WR   = 3'd5;
  localparam logic [2:0] OP_RD   = 3'd6;
  localparam logic [2:0] OP_TAGS = 3'd7;

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, CAPTURE, RESPOND
  } state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [NUM_BITS-1:0] r_data;
  logic [7:0]          r_cnt;

  logic [NUM_BITS-1:0]   w_tags_ext;
  logic [2*NUM_BITS-1:0] w_wr;

  assign cmd_ready  = (r_state == IDLE) && reset_n;
  assign w_tags_ext = NUM_BITS'(tag_wires);

  // Two-rail write drive: bit 2i+1 writes a one, bit 2i writes a zero.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      w_wr[2*i+1] = mask[i] & r_data[i];
      w_wr[2*i]   = mask[i] & ~r_data[i];
    end
  end

`ifdef CAM_SEQ_TAG_COUNT_EN
  localparam int CW = $clog2(NUM_CELLS + 1);
  logic [CW-1:0] w_count;
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_CELLS; i++)
      w_count = w_count + CW'(tag_wires[i]);
  end
`endif

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_op           <= OP_NOP;
      r_data         <= '0;
      r_cnt          <= '0;
      comparand      <= '0;
      mask           <= '0;
      perform_search <= 1'b0;
      set            <= 1'b0;
      select_first   <= 1'b0;
      write_lines    <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_data  <= cmd_data;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          r_state   <= RESPOND;
          unique case (r_op)
            OP_NOP:  rsp_data <= '0;
            OP_LCMP: begin
              comparand <= r_data;
              rsp_data  <= r_data;
            end
            OP_LMSK: begin
              mask     <= r_data;
              rsp_data <= r_data;
            end
            OP_SRCH: begin
              perform_search <= 1'b1;
              rsp_valid      <= 1'b0;
              r_cnt          <= CNT_INIT;
              r_state        <= SETTLE;
            end
            OP_SELF: begin
              select_first <= 1'b1;
              rsp_valid    <= 1'b0;
              r_cnt        <= CNT_INIT;
              r_state      <= SETTLE;
            end
            OP_WR: begin
              set         <= 1'b1;
              write_lines <= w_wr;
              rsp_valid   <= 1'b0;
              r_cnt       <= CNT_INIT;
              r_state     <= SETTLE;
            end
            OP_RD:   rsp_data <= read_lines;
            OP_TAGS: rsp_data <= w_tags_ext;
          endcase
        end
        SETTLE: begin
          // Dropping on the last count keeps the strobe exactly SC wide.
          if (r_cnt == 8'd0) begin
            perform_search <= 1'b0;
            set            <= 1'b0;
            select_first   <= 1'b0;
            write_lines    <= '0;
            r_state        <= CAPTURE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          r_state   <= RESPOND;
          if (r_op == OP_WR) begin
            rsp_data <= '0;
          end else if (r_op == OP_SRCH) begin
`ifdef CAM_SEQ_TAG_COUNT_EN
            rsp_data <= NUM_BITS'(w_count);
            rsp_err  <= (w_count == '0);
`else
            rsp_data <= w_tags_ext;
`endif
          end else begin
            rsp_data <= w_tags_ext;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Directed self-checking bench for cam_cmd_sequencer.
// Expected SEARCH results follow CAM_SEQ_TAG_COUNT_EN when defined.
module tb_cam_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] comparand;
  logic [31:0] mask;
  logic        perform_search;
  logic        set;
  logic        select_first;
  logic [63:0] write_lines;
  logic [15:0] tag_wires;
  logic [31:0] read_lines;

  int checks = 0;
  int errors = 0;
  int ps_cnt = 0;
  int st_cnt = 0;
  int sf_cnt = 0;
  int multi  = 0;
  int wl_bad = 0;
  logic [63:0] exp_wl = '0;

  always #5 clk = ~clk;

  cam_cmd_sequencer #(
    .NUM_BITS(32), .NUM_CELLS(16), .SETTLE_CYCLES(5)
  ) dut (
    .clk_48mhz(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .comparand(comparand), .mask(mask),
    .perform_search(perform_search), .set(set),
    .select_first(select_first), .write_lines(write_lines),
    .tag_wires(tag_wires), .read_lines(read_lines)
  );

  // Strobe width, exclusivity and write-drive observers.
  always @(negedge clk) begin
    if (perform_search) ps_cnt++;
    if (set) st_cnt++;
    if (select_first) sf_cnt++;
    if ($countones({perform_search, set, select_first}) > 1) multi++;
    if (set ? (write_lines !== exp_wl) : (write_lines !== 64'd0)) wl_bad++;
  end

  task automatic send(input logic [2:0] op, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic re);
    int n;
    lat = 0; rd = '0; re = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_op%0d: cmd_ready=0, want 1", op);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ps_cnt = 0; st_cnt = 0; sf_cnt = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    lat = n; rd = rsp_data; re = rsp_err;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout_op%0d: rsp_valid=0 after %0d, want 1", op, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({comparand, mask, rsp_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_regs: cmp=%h mask=%h rsp=%h, want 0", comparand, mask, rsp_data);
    end
    checks++;
    if ({perform_search, set, select_first, rsp_valid, rsp_err} !== 5'd0) begin
      errors++;
      $display("FAIL reset_strobes: %b, want 00000",
               {perform_search, set, select_first, rsp_valid, rsp_err});
    end
    checks++;
    if (write_lines !== 64'd0) begin
      errors++;
      $display("FAIL reset_wl: got %h, want 0", write_lines);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b, want 0", cmd_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_high: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_load;
    int lat; logic [31:0] rd; logic re;
    send(3'd1, 32'hDEADBEEF, lat, rd, re);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL lcmp_latency: got %0d, want 2", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || re !== 1'b0) begin
      errors++;
      $display("FAIL lcmp_rsp: got %h/%b, want deadbeef/0", rd, re);
    end
    checks++;
    if (comparand !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lcmp_reg: got %h, want deadbeef", comparand);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lcmp_handshake: rsp_valid=%b, want 0", rsp_valid);
    end
    send(3'd2, 32'h0000FFFF, lat, rd, re);
    checks++;
    if (rd !== 32'h0000FFFF || mask !== 32'h0000FFFF || lat != 2) begin
      errors++;
      $display("FAIL lmsk: rsp=%h mask=%h lat=%0d, want 0000ffff/0000ffff/2", rd, mask, lat);
    end
  endtask

  task automatic test_search;
    int lat; logic [31:0] rd; logic re;
    logic [31:0] e1, e2;
    logic x1, x2;
`ifdef CAM_SEQ_TAG_COUNT_EN
    e1 = 32'd2; x1 = 1'b0; e2 = 32'd0; x2 = 1'b1;
`else
    e1 = 32'h5; x1 = 1'b0; e2 = 32'd0; x2 = 1'b0;
`endif
    tag_wires = 16'h0005;
    send(3'd3, 32'h0, lat, rd, re);
    checks++;
    if (ps_cnt != 5) begin
      errors++;
      $display("FAIL search_width: got %0d, want 5", ps_cnt);
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL search_latency: got %0d, want 8", lat);
    end
    checks++;
    if (rd !== e1 || re !== x1) begin
      errors++;
      $display("FAIL search_rsp: got %h/%b, want %h/%b", rd, re, e1, x1);
    end
    tag_wires = 16'h0000;
    send(3'd3, 32'h0, lat, rd, re);
    checks++;
    if (rd !== e2 || re !== x2) begin
      errors++;
      $display("FAIL search_empty: got %h/%b, want %h/%b", rd, re, e2, x2);
    end
  endtask

  task automatic test_write;
    int lat; logic [31:0] rd; logic re;
    send(3'd2, 32'h000000FF, lat, rd, re);
    exp_wl = 64'h0000_0000_0000_9966;
    wl_bad = 0;
    send(3'd5, 32'h000000A5, lat, rd, re);
    checks++;
    if (st_cnt != 5) begin
      errors++;
      $display("FAIL write_width: got %0d, want 5", st_cnt);
    end
    checks++;
    if (wl_bad != 0) begin
      errors++;
      $display("FAIL write_lines: %0d bad cycles, want 0 (9966 under set)", wl_bad);
    end
    checks++;
    if (rd !== 32'd0 || lat != 8 || write_lines !== 64'd0) begin
      errors++;
      $display("FAIL write_rsp: rsp=%h lat=%0d wl=%h, want 0/8/0", rd, lat, write_lines);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    rsp_ready = 1'b0;
    tag_wires = 16'h0030;
    @(negedge clk);
    cmd_op = 3'd4; cmd_data = 32'h0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = 3'd1; cmd_data = 32'h11111111;
    sf_cnt = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    checks++;
    if (!rsp_valid || n != 8) begin
      errors++;
      $display("FAIL bp_latency: valid=%b lat=%0d, want 1/8", rsp_valid, n);
    end
    tag_wires = 16'h00FF;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h30 || cmd_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d bad cycles, want 0", bad);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b ready=%b, want 0/1", rsp_valid, cmd_ready);
    end
    checks++;
    if (comparand !== 32'hDEADBEEF || sf_cnt != 5) begin
      errors++;
      $display("FAIL bp_ignored: cmp=%h sf=%0d, want deadbeef/5", comparand, sf_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    tag_wires = 16'h0003;
    @(negedge clk);
    cmd_op = 3'd3; cmd_data = 32'h0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!perform_search && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (perform_search !== 1'b1) begin
      errors++;
      $display("FAIL mid_strobe: got %b, want 1", perform_search);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (perform_search !== 1'b0 || rsp_valid !== 1'b0 || comparand !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: ps=%b valid=%b cmp=%h, want 0/0/0",
               perform_search, rsp_valid, comparand);
    end
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || perform_search) seen++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || seen != 0) begin
      errors++;
      $display("FAIL mid_after: ready=%b activity=%0d, want 1/0", cmd_ready, seen);
    end
  endtask

  task automatic test_read_tags;
    int lat; logic [31:0] rd; logic re;
    read_lines = 32'h12345678;
    send(3'd6, 32'h0, lat, rd, re);
    checks++;
    if (rd !== 32'h12345678 || lat != 2) begin
      errors++;
      $display("FAIL read_rsp: got %h lat=%0d, want 12345678/2", rd, lat);
    end
    checks++;
    if (ps_cnt + st_cnt + sf_cnt != 0) begin
      errors++;
      $display("FAIL read_nostrobe: %0d strobe cycles, want 0", ps_cnt + st_cnt + sf_cnt);
    end
    tag_wires = 16'hBEEF;
    send(3'd7, 32'h0, lat, rd, re);
    checks++;
    if (rd !== 32'h0000BEEF || re !== 1'b0) begin
      errors++;
      $display("FAIL get_tags: got %h/%b, want 0000beef/0", rd, re);
    end
    send(3'd0, 32'hFFFFFFFF, lat, rd, re);
    checks++;
    if (rd !== 32'd0 || lat != 2) begin
      errors++;
      $display("FAIL nop: got %h lat=%0d, want 0/2", rd, lat);
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL one_hot: %0d overlap cycles, want 0", multi);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_data = '0;
    rsp_ready = 1'b1;
    tag_wires = '0;
    read_lines = '0;
    test_reset;
    test_load;
    test_search;
    test_write;
    test_backpressure;
    test_reset_mid;
    test_read_tags;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
